// File: rtl/agg_switch.sv
// agg_switch: selects one of NUM_SRC aggregate sources (LANES lanes of WIDTH
// bits each) onto a registered aggregate output. A source change goes through
// a valid/ready request handshake and then BLANK_CYC cycles of blanked output,
// so the consumer never sees a mixed-source aggregate.
//
// Optional build macro: AGG_SWITCH_HOLD_EN -- when defined, out_data holds its
// last settled value during blanking instead of going to zero.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   src_data        source s, lane l at [(s*LANES+l)*WIDTH +: WIDTH]
//   sel_req_valid   switch request valid
//   sel_req_idx     requested source index
//   sel_req_ready   request can be accepted (high while running)
//   err_clr         clears sel_err
//   out_data        registered aggregate, lane l at [l*WIDTH +: WIDTH]
//   out_valid       out_data is a settled source sample
//   cur_sel         committed source index
//   sel_err         sticky out-of-range request flag

// One output lane: picks its lane from the committed source, or blanks.
module agg_switch_lane #(
  parameter int WIDTH   = 3,
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0][WIDTH-1:0]   lane_src,
  input  logic [SEL_W-1:0]                sel,
  input  logic                            blank,
  output logic [WIDTH-1:0]                lane_q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
    end else if (!blank) begin
      lane_q <= lane_src[sel];
    end else begin
`ifdef AGG_SWITCH_HOLD_EN
      lane_q <= lane_q;
`else
      lane_q <= '0;
`endif
    end
  end
endmodule

module agg_switch #(
  parameter int WIDTH     = 3,
  parameter int LANES     = 3,
  parameter int NUM_SRC   = 2,
  parameter int BLANK_CYC = 2,
  parameter int RST_SEL   = 0
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [NUM_SRC*LANES*WIDTH-1:0]                     src_data,
  input  logic                                               sel_req_valid,
  input  logic [((NUM_SRC > 2) ? $clog2(NUM_SRC) : 1)-1:0]  sel_req_idx,
  output logic                                               sel_req_ready,
  input  logic                                               err_clr,
  output logic [LANES*WIDTH-1:0]                             out_data,
  output logic                                               out_valid,
  output logic [((NUM_SRC > 2) ? $clog2(NUM_SRC) : 1)-1:0]  cur_sel,
  output logic                                               sel_err
);
  localparam int SEL_W = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;
  // Counter holds BLANK_CYC-1 down to 0; keep at least one bit.
  localparam int CNT_W = (BLANK_CYC > 2) ? $clog2(BLANK_CYC) : 1;
  localparam logic [SEL_W-1:0] RST_IDX  = SEL_W'(RST_SEL);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic {RUN, BLANK} state_t;

  state_t           state;
  logic [CNT_W-1:0] blank_cnt;
  logic             idx_bad;

  logic [LANES-1:0][NUM_SRC-1:0][WIDTH-1:0] lane_view;
  logic [LANES-1:0][WIDTH-1:0]              lane_q;

  assign sel_req_ready = (state == RUN);

  // Only non-power-of-two source counts have unused (invalid) index codes.
  generate
    if (NUM_SRC == (1 << SEL_W)) begin : g_full_idx
      assign idx_bad = 1'b0;
    end else begin : g_part_idx
      assign idx_bad = (sel_req_idx > SEL_W'(NUM_SRC - 1));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cur_sel   <= RST_IDX;
      blank_cnt <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      out_valid <= (state == RUN);
      // Clear first so a same-cycle invalid request below wins.
      if (err_clr) sel_err <= 1'b0;
      case (state)
        RUN: begin
          if (sel_req_valid) begin
            if (idx_bad) begin
              sel_err <= 1'b1;
            end else if (sel_req_idx != cur_sel) begin
              cur_sel <= sel_req_idx;
              if (BLANK_CYC > 0) begin
                state     <= BLANK;
                blank_cnt <= CNT_LOAD;
              end
            end
          end
        end
        BLANK: begin
          if (blank_cnt == '0) state <= RUN;
          else                 blank_cnt <= blank_cnt - CNT_W'(1);
        end
        default: state <= RUN;
      endcase
    end
  end

  // Regroup the flat source bus by lane so each lane mux sees all sources.
  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        assign lane_view[l][s] = src_data[(s*LANES+l)*WIDTH +: WIDTH];
      end

      agg_switch_lane #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .lane_src (lane_view[l]),
        .sel      (cur_sel),
        .blank    (state == BLANK),
        .lane_q   (lane_q[l])
      );

      assign out_data[l*WIDTH +: WIDTH] = lane_q[l];
    end
  endgenerate

endmodule
